// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS data-memory responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: the responder FSM state encoding, the access fault codes and the
// default geometry/timing constants used by mips_dmem_responder.
package mips_pkg;

    // Default memory size in words (must be a power of two).
    localparam int DMEM_DEPTH_DEFAULT = 64;

    // Default number of wait states per access (legal range 0..15).
    localparam int DMEM_WAIT_DEFAULT  = 2;

    // Width of the wait-state counter; covers the 0..15 range.
    localparam int DMEM_CNT_W         = 4;

    // Responder FSM: accept in IDLE, burn wait states in WAIT, pulse in RESP.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Why an access was refused. FAULT_ALIGN is only raised when the
    // alignment check is compiled in.
    typedef enum logic [1:0] {
        FAULT_NONE  = 2'd0,
        FAULT_RANGE = 2'd1,
        FAULT_ALIGN = 2'd2
    } dmem_fault_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage for the data-memory responder.
// Latency: write commits on the clock edge; read data is registered on the same edge.
// Backpressure: none; the owner issues at most one access per edge.
//
// Ports:
//   clk    - clock
//   we     - write enable: mem[idx] <= wdata
//   re     - read enable:  rdata   <= mem[idx]
//   idx    - word index
//   wdata  - write data
//   rdata  - registered read data (holds its value between reads)
//
// The array has no reset: contents survive rst_n by design.
module dmem_array
    import mips_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = DMEM_DEPTH_DEFAULT,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] idx,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the MIPS memory stage: one load/store at a time with fixed wait states.
// Latency: accept at edge N -> rsp_valid in the cycle following edge N+WAIT_CYCLES; one access per WAIT_CYCLES+2 cycles.
// Backpressure: req_ready only in IDLE; stall freezes the pipeline from request until the response cycle.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   req_valid/req_we    - request strobe, 1 = store / 0 = load
//   req_addr/req_wdata  - byte address and store data
//   req_ready           - request accepted this cycle (IDLE)
//   rsp_valid           - one-cycle completion pulse
//   rsp_rdata/rsp_err   - load data / access fault, both zero outside rsp_valid
//   stall               - freeze request to the hazard unit
//
// Build option: define DMEM_ALIGN_CHECK_EN to fault on req_addr[1:0] != 0.
// Without it the low address bits are ignored and only the range check applies.
module mips_dmem_responder
    import mips_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = DMEM_DEPTH_DEFAULT,
    parameter int WAIT_CYCLES = DMEM_WAIT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             req_ready,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             stall
);

    localparam int                  IDX_W      = $clog2(DEPTH);
    // First byte address past the end of the array.
    localparam logic [WIDTH-1:0]    ADDR_LIMIT = WIDTH'(DEPTH) << 2;
    localparam logic [DMEM_CNT_W-1:0] WAIT_INIT = DMEM_CNT_W'(WAIT_CYCLES);
    localparam bit                  NO_WAIT    = (WAIT_CYCLES == 0);

    dmem_state_t            state;
    logic [DMEM_CNT_W-1:0]  cnt;

    // Request captured at acceptance; frozen for the rest of the access.
    logic                   lat_we;
    logic [WIDTH-1:0]       lat_addr;
    logic [WIDTH-1:0]       lat_wdata;

    // Response registers, loaded on the edge that enters RESP.
    logic                   rsp_valid_q;
    dmem_fault_t            rsp_fault_q;
    logic                   rsp_we_q;

    // Access actually performed on the array this edge.
    logic                   accept;
    logic                   enter_resp;
    logic                   acc_we;
    logic [WIDTH-1:0]       acc_addr;
    logic [WIDTH-1:0]       acc_wdata;
    dmem_fault_t            acc_fault;
    logic                   arr_we;
    logic                   arr_re;
    logic [WIDTH-1:0]       arr_rdata;

    assign accept = (state == IDLE) && req_valid;

    // With zero wait states the array access happens on the acceptance edge
    // itself, before the latches hold anything, so the live request is used.
    assign acc_we    = NO_WAIT ? req_we    : lat_we;
    assign acc_addr  = NO_WAIT ? req_addr  : lat_addr;
    assign acc_wdata = NO_WAIT ? req_wdata : lat_wdata;

    assign enter_resp = NO_WAIT ? accept
                                : ((state == WAIT) && (cnt == DMEM_CNT_W'(1)));

    // The full address takes part in the range compare, so anything at or
    // above DEPTH*4 faults instead of aliasing onto a low word.
    always_comb begin
        acc_fault = FAULT_NONE;
        if (acc_addr >= ADDR_LIMIT) begin
            acc_fault = FAULT_RANGE;
        end
`ifdef DMEM_ALIGN_CHECK_EN
        else if (acc_addr[1:0] != 2'b00) begin
            acc_fault = FAULT_ALIGN;
        end
`endif
    end

    assign arr_we = enter_resp &&  acc_we && (acc_fault == FAULT_NONE);
    assign arr_re = enter_resp && !acc_we && (acc_fault == FAULT_NONE);

    dmem_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .idx   (acc_addr[IDX_W+1:2]),
        .wdata (acc_wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= FAULT_NONE;
            rsp_we_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        cnt       <= WAIT_INIT;
                        state     <= NO_WAIT ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - DMEM_CNT_W'(1);
                    if (cnt == DMEM_CNT_W'(1)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_fault_q <= FAULT_NONE;
                    rsp_we_q    <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Never true while in RESP, so it cannot collide with the clear above.
            if (enter_resp) begin
                rsp_valid_q <= 1'b1;
                rsp_fault_q <= acc_fault;
                rsp_we_q    <= acc_we;
            end
        end
    end

    assign req_ready = (state == IDLE);
    assign stall     = ((state == IDLE) && req_valid) || (state == WAIT);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_valid_q && (rsp_fault_q != FAULT_NONE);

    // The array read register keeps stale data between loads; expose it only
    // for a successful load response.
    assign rsp_rdata = (rsp_valid_q && (rsp_fault_q == FAULT_NONE) && !rsp_we_q)
                       ? arr_rdata : '0;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Bench for mips_dmem_responder: two instances (2 wait states and 0 wait states)
// driven with directed and random loads/stores, compared every cycle against a
// timing/memory model, plus literal expectations on selected transactions.
module tb_mips_dmem_responder;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       vld;
    logic [1:0]       we_r;
    logic [1:0][31:0] addr_r;
    logic [1:0][31:0] wd_r;
    logic [1:0]       ready;
    logic [1:0]       rvalid;
    logic [1:0][31:0] rdata;
    logic [1:0]       rerr;
    logic [1:0]       stl;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips_dmem_responder #(.WIDTH(32), .DEPTH(64), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(vld[0]), .req_we(we_r[0]), .req_addr(addr_r[0]), .req_wdata(wd_r[0]),
        .req_ready(ready[0]), .rsp_valid(rvalid[0]), .rsp_rdata(rdata[0]),
        .rsp_err(rerr[0]), .stall(stl[0])
    );

    mips_dmem_responder #(.WIDTH(32), .DEPTH(64), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(vld[1]), .req_we(we_r[1]), .req_addr(addr_r[1]), .req_wdata(wd_r[1]),
        .req_ready(ready[1]), .rsp_valid(rvalid[1]), .rsp_rdata(rdata[1]),
        .rsp_err(rerr[1]), .stall(stl[1])
    );

    // ---------------- behavioural model ----------------
    // An instance is busy from its acceptance edge until the edge that ends
    // the response cycle; the response is the cycle after edge t_acc+wc.
    int          wcs [2] = '{2, 0};
    int          cyc = 0;
    bit          busy [2];
    int          t_acc [2];
    int          acc_cnt [2];
    bit          op_we [2];
    logic [31:0] op_addr [2];
    logic [31:0] op_wd [2];
    logic [31:0] mem_m [2][64];
    logic [31:0] exp_rdata [2];
    bit          exp_err [2];
    logic [31:0] last_rdata [2];
    bit          last_err [2];
    int          last_rsp_cyc [2];

    function automatic bit is_fault(input logic [31:0] a);
        bit f;
        f = (a >= 32'd256);
`ifdef DMEM_ALIGN_CHECK_EN
        if (a[1:0] != 2'b00) f = 1'b1;
`endif
        return f;
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] at cycle %0d: got %h expected %h", nm, i, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                busy[i] = 1'b0;
            end else if (busy[i]) begin
                if (cyc == t_acc[i] + wcs[i] + 1) busy[i] = 1'b0;
            end else if (vld[i]) begin
                busy[i]    = 1'b1;
                t_acc[i]   = cyc;
                op_we[i]   = we_r[i];
                op_addr[i] = addr_r[i];
                op_wd[i]   = wd_r[i];
                acc_cnt[i] = acc_cnt[i] + 1;
            end
            if (busy[i] && cyc == t_acc[i] + wcs[i]) begin
                exp_err[i] = is_fault(op_addr[i]);
                if (op_we[i] && !exp_err[i]) mem_m[i][op_addr[i][7:2]] = op_wd[i];
                exp_rdata[i] = (!op_we[i] && !exp_err[i]) ? mem_m[i][op_addr[i][7:2]] : 32'h0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit rv;
            rv = busy[i] && (cyc == t_acc[i] + wcs[i]);
            chk("req_ready", i, ready[i], !busy[i]);
            chk("stall", i, stl[i], (!busy[i] && vld[i]) || (busy[i] && cyc < t_acc[i] + wcs[i]));
            chk("rsp_valid", i, rvalid[i], rv);
            chk("rsp_rdata", i, rdata[i], rv ? exp_rdata[i] : 32'h0);
            chk("rsp_err", i, rerr[i], rv ? exp_err[i] : 1'b0);
            if (rvalid[i]) begin
                last_rdata[i]   = rdata[i];
                last_err[i]     = rerr[i];
                last_rsp_cyc[i] = cyc;
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at posedge+1 of an idle cycle; returns at posedge+1 of the next idle cycle.
    task automatic do_op(input int i, input bit w, input logic [31:0] a, input logic [31:0] d, input bit junk);
        int n;
        n = acc_cnt[i];
        vld[i] = 1'b1; we_r[i] = w; addr_r[i] = a; wd_r[i] = d;
        for (int k = 0; k < 40 && acc_cnt[i] == n; k++) begin
            @(posedge clk); #1;
        end
        if (acc_cnt[i] == n) begin
            total++; bad++;
            $display("FAIL accept_timeout[%0d]: got no acceptance expected one", i);
        end
        for (int k = 0; k < 40 && busy[i]; k++) begin
            if (junk) begin
                vld[i] = 1'b1; we_r[i] = 1'($urandom);
                addr_r[i] = $urandom; wd_r[i] = $urandom;
            end else begin
                vld[i] = 1'b0;
            end
            @(posedge clk); #1;
        end
        vld[i] = 1'b0;
    endtask

    task automatic init_mem(input int i);
        for (int w = 0; w < 64; w++) do_op(i, 1'b1, 32'(w) << 2, 32'hA500_0000 | 32'(w), 1'b0);
    endtask

    task automatic rand_ops(input int i, input int n);
        logic [31:0] a;
        for (int k = 0; k < n; k++) begin
            case ($urandom_range(0, 7))
                5:       a = 32'($urandom_range(0, 255));
                6:       a = 32'($urandom_range(256, 1023));
                7:       a = $urandom;
                default: a = 32'($urandom_range(0, 63)) << 2;
            endcase
            do_op(i, 1'($urandom), a, $urandom, 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        int a1, a2, n;
        rst_n = 1'b0; vld = '0; we_r = '0; addr_r = '0; wd_r = '0;
        #3;
        for (int i = 0; i < 2; i++) begin
            chk("reset_ready", i, ready[i], 1'b1);
            chk("reset_rsp_valid", i, rvalid[i], 1'b0);
            chk("reset_rsp_rdata", i, rdata[i], 32'h0);
            chk("reset_rsp_err", i, rerr[i], 1'b0);
            chk("reset_stall", i, stl[i], 1'b0);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        fork
            init_mem(0);
            init_mem(1);
        join

        // Store then load, two wait states.
        do_op(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        do_op(0, 1'b0, 32'h10, 32'h0, 1'b0);
        chk("st_ld_rdata", 0, last_rdata[0], 32'hDEADBEEF);
        chk("st_ld_err", 0, last_err[0], 1'b0);
        chk("st_ld_latency", 0, last_rsp_cyc[0] - t_acc[0], 2);

        // Out of range.
        do_op(0, 1'b0, 32'h100, 32'h0, 1'b0);
        chk("oor_ld_err", 0, last_err[0], 1'b1);
        chk("oor_ld_rdata", 0, last_rdata[0], 32'h0);
        do_op(0, 1'b1, 32'h100, 32'h12345678, 1'b0);
        chk("oor_st_err", 0, last_err[0], 1'b1);
        do_op(0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("oor_st_nowrite", 0, last_rdata[0], 32'hA500_0000);

        // Misaligned store to 0x12.
        do_op(0, 1'b1, 32'h12, 32'hCAFEF00D, 1'b0);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("misalign_st_err", 0, last_err[0], 1'b1);
        do_op(0, 1'b0, 32'h10, 32'h0, 1'b0);
        chk("misalign_word4", 0, last_rdata[0], 32'hDEADBEEF);
`else
        chk("misalign_st_err", 0, last_err[0], 1'b0);
        do_op(0, 1'b0, 32'h10, 32'h0, 1'b0);
        chk("misalign_word4", 0, last_rdata[0], 32'hCAFEF00D);
`endif

        // Changing request inputs during WAIT must not disturb the access.
        do_op(0, 1'b1, 32'h20, 32'h0BADF00D, 1'b1);
        do_op(0, 1'b0, 32'h20, 32'h0, 1'b0);
        chk("held_req_rdata", 0, last_rdata[0], 32'h0BADF00D);

        // Zero wait states: back-to-back loads every two cycles.
        do_op(1, 1'b1, 32'h40, 32'h55AA55AA, 1'b0);
        n = acc_cnt[1];
        a1 = -100; a2 = 0;
        vld[1] = 1'b1; we_r[1] = 1'b0; addr_r[1] = 32'h40;
        for (int k = 0; k < 20 && acc_cnt[1] < n + 2; k++) begin
            @(posedge clk); #1;
            if (acc_cnt[1] == n + 1 && a1 < 0) a1 = t_acc[1];
        end
        a2 = t_acc[1];
        vld[1] = 1'b0;
        for (int k = 0; k < 20 && busy[1]; k++) begin
            @(posedge clk); #1;
        end
        chk("wc0_b2b_spacing", 1, a2 - a1, 2);
        chk("wc0_latency", 1, last_rsp_cyc[1] - a2, 0);
        chk("wc0_rdata", 1, last_rdata[1], 32'h55AA55AA);

        // Reset during WAIT drops the store.
        n = acc_cnt[0];
        vld[0] = 1'b1; we_r[0] = 1'b1; addr_r[0] = 32'h30; wd_r[0] = 32'h11111111;
        for (int k = 0; k < 20 && acc_cnt[0] == n; k++) begin
            @(posedge clk); #1;
        end
        vld[0] = 1'b0;
        #2;
        rst_n = 1'b0;
        busy[0] = 1'b0; busy[1] = 1'b0;
        #1;
        chk("midwait_rst_valid", 0, rvalid[0], 1'b0);
        chk("midwait_rst_rdata", 0, rdata[0], 32'h0);
        chk("midwait_rst_err", 0, rerr[0], 1'b0);
        chk("midwait_rst_ready", 0, ready[0], 1'b1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        do_op(0, 1'b0, 32'h30, 32'h0, 1'b0);
        chk("midwait_rst_old", 0, last_rdata[0], 32'hA500_000C);

        fork
            rand_ops(0, 150);
            rand_ops(1, 150);
        join
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
